// File: rtl/md5_pad_feeder.sv
// Byte-stream front end for the md5 core: packs bytes into 128-bit beats, applies MD5 padding and length,
// drives newtext/load per block and captures the digest. Optional MD5_FEED_BSWAP_EN byte-swaps digest words.
module md5_pad_feeder #(
   parameter int LEN_W = 61
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   byte_i,
   input  logic         valid_i,
   input  logic         last_i,
   output logic         in_ready_o,
   output logic         newtext_o,
   output logic         load_o,
   output logic [127:0] blk_o,
   input  logic         core_ready_i,
   input  logic [127:0] core_data_i,
   output logic         done_o,
   output logic [127:0] digest_o
);

   typedef enum logic [2:0] {IDLE, ABSORB, LOAD, PAD, WAIT} state_t;

   state_t             state;
   logic [127:0]       beat_buf;
   logic [3:0]         p;
   logic [1:0]         b;
   logic [LEN_W-1:0]   cnt;
   logic               sent80;
   logic               carry;
   logic               final_blk;
   logic               ret_pad;

   logic               accept;
   logic [5:0]         pos;
   logic [63:0]        bit_len;
   logic [7:0]         pad_b;
   logic [127:0]       digest_nxt;

   // Byte p of a beat: word p/4 from the top, byte p%4 from the bottom of that word.
   function automatic logic [127:0] put_byte(input logic [127:0] beat, input logic [3:0] idx,
                                             input logic [7:0] val);
      logic [127:0] r;
      int           lsb;
      r   = beat;
      lsb = 96 - 32 * int'(idx[3:2]) + 8 * int'(idx[1:0]);
      r[lsb +: 8] = val;
      return r;
   endfunction

   function automatic logic [7:0] pad_byte(input logic s80, input logic cry, input logic [5:0] ps,
                                           input logic [63:0] len);
      logic [7:0] r;
      if (!s80)
         r = 8'h80;
      else if (!cry && ps >= 6'd56)
         r = len[8 * int'(ps[2:0]) +: 8];
      else
         r = 8'h00;
      return r;
   endfunction

`ifdef MD5_FEED_BSWAP_EN
   function automatic logic [127:0] word_bswap(input logic [127:0] d);
      logic [127:0] r;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            r[32*k + 8*j +: 8] = d[32*k + 24 - 8*j +: 8];
      return r;
   endfunction

   assign digest_nxt = word_bswap(core_data_i);
`else
   assign digest_nxt = core_data_i;
`endif

   assign accept  = valid_i & in_ready_o;
   assign pos     = {b, p};
   assign bit_len = 64'({cnt, 3'b000});
   assign pad_b   = pad_byte(sent80, carry, pos, bit_len);
   assign blk_o   = beat_buf;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         beat_buf   <= '0;
         p          <= '0;
         b          <= '0;
         cnt        <= '0;
         sent80     <= 1'b0;
         carry      <= 1'b0;
         final_blk  <= 1'b0;
         ret_pad    <= 1'b0;
         in_ready_o <= 1'b0;
         newtext_o  <= 1'b0;
         load_o     <= 1'b0;
         done_o     <= 1'b0;
         digest_o   <= '0;
      end else begin
         newtext_o <= 1'b0;
         load_o    <= 1'b0;
         done_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  newtext_o <= 1'b1;
                  beat_buf  <= put_byte(beat_buf, 4'd0, byte_i);
                  p         <= 4'd1;
                  b         <= 2'd0;
                  cnt       <= LEN_W'(1);
                  sent80    <= 1'b0;
                  carry     <= 1'b0;
                  final_blk <= 1'b0;
                  if (last_i) begin
                     state      <= PAD;
                     in_ready_o <= 1'b0;
                  end else begin
                     state <= ABSORB;
                  end
               end else begin
                  in_ready_o <= 1'b1;
               end
            end
            ABSORB: begin
               if (accept) begin
                  beat_buf <= put_byte(beat_buf, p, byte_i);
                  cnt      <= cnt + LEN_W'(1);
                  if (p == 4'd15) begin
                     p          <= 4'd0;
                     state      <= LOAD;
                     load_o     <= 1'b1;
                     ret_pad    <= last_i;
                     in_ready_o <= 1'b0;
                  end else begin
                     p <= p + 4'd1;
                     if (last_i) begin
                        state      <= PAD;
                        in_ready_o <= 1'b0;
                     end
                  end
               end
            end
            LOAD: begin
               if (b == 2'd3) begin
                  state <= WAIT;
               end else begin
                  b          <= b + 2'd1;
                  state      <= ret_pad ? PAD : ABSORB;
                  in_ready_o <= !ret_pad;
               end
            end
            PAD: begin
               beat_buf <= put_byte(beat_buf, p, pad_b);
               if (!sent80) begin
                  sent80 <= 1'b1;
                  // A marker in the last 8 positions pushes the length into a fresh block.
                  if (pos >= 6'd56)
                     carry <= 1'b1;
               end
               if (sent80 && !carry && pos == 6'd63)
                  final_blk <= 1'b1;
               if (p == 4'd15) begin
                  p       <= 4'd0;
                  state   <= LOAD;
                  load_o  <= 1'b1;
                  ret_pad <= 1'b1;
               end else begin
                  p <= p + 4'd1;
               end
            end
            WAIT: begin
               if (core_ready_i) begin
                  b     <= 2'd0;
                  carry <= 1'b0;
                  if (final_blk) begin
                     digest_o   <= digest_nxt;
                     done_o     <= 1'b1;
                     final_blk  <= 1'b0;
                     sent80     <= 1'b0;
                     state      <= IDLE;
                     in_ready_o <= 1'b1;
                  end else begin
                     state      <= ret_pad ? PAD : ABSORB;
                     in_ready_o <= !ret_pad;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               in_ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_pad_feeder.sv
// Self-checking bench for md5_pad_feeder: padded-message beat scoreboard, behavioural core stand-in, digest queue.
module tb_md5_pad_feeder;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   byte_i;
   logic         valid_i;
   logic         last_i;
   logic         in_ready_o;
   logic         newtext_o;
   logic         load_o;
   logic [127:0] blk_o;
   logic         core_ready_i;
   logic [127:0] core_data_i;
   logic         done_o;
   logic [127:0] digest_o;

   always #5 clk = ~clk;

   md5_pad_feeder dut (
      .clk(clk), .reset(reset), .byte_i(byte_i), .valid_i(valid_i), .last_i(last_i),
      .in_ready_o(in_ready_o), .newtext_o(newtext_o), .load_o(load_o), .blk_o(blk_o),
      .core_ready_i(core_ready_i), .core_data_i(core_data_i), .done_o(done_o), .digest_o(digest_o)
   );

   localparam logic [127:0] ABC_CORE = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
   localparam logic [127:0] A_CORE   = 128'hb975c10c_a8b6f1c0_e299c331_61267769;
`ifdef MD5_FEED_BSWAP_EN
   localparam logic [127:0] ABC_DIG  = 128'h90015098_3cd24fb0_d6963f7d_28e17f72;
   localparam logic [127:0] A_DIG    = 128'h0cc175b9_c0f1b6a8_31c399e2_69772661;
`else
   localparam logic [127:0] ABC_DIG  = ABC_CORE;
   localparam logic [127:0] A_DIG    = A_CORE;
`endif

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_beats[$];
   logic [127:0] exp_dig[$];
   int           msg_blk_q[$];
   logic [127:0] fin_core_q[$];
   logic [127:0] beats_log[64];
   int n_loads, n_nt, n_done, n_ready, core_delay, ir_viol, over_loads;

   task automatic clear_stats();
      n_loads = 0; n_nt = 0; n_done = 0; n_ready = 0; ir_viol = 0; over_loads = 0;
   endtask

   // Reference: pad the message, then pack each 16 bytes as {w0,w1,w2,w3}, w = {b3,b2,b1,b0}.
   task automatic push_expect(input logic [7:0] msg[$], input logic [127:0] core, input logic [127:0] dig);
      logic [7:0]   pd[$];
      logic [63:0]  bl;
      logic [31:0]  w[4];
      pd = msg;
      pd.push_back(8'h80);
      while (pd.size() % 64 != 56) pd.push_back(8'h00);
      bl = 64'(msg.size()) * 64'd8;
      for (int i = 0; i < 8; i++) pd.push_back(bl[8*i +: 8]);
      for (int i = 0; i < pd.size(); i += 16) begin
         for (int k = 0; k < 4; k++)
            w[k] = {pd[i+4*k+3], pd[i+4*k+2], pd[i+4*k+1], pd[i+4*k]};
         exp_beats.push_back({w[0], w[1], w[2], w[3]});
      end
      msg_blk_q.push_back(pd.size() / 64);
      fin_core_q.push_back(core);
      exp_dig.push_back(dig);
   endtask

   task automatic send_bytes(input logic [7:0] msg[$], input bit gaps, input bit keep);
      bit acc;
      int budget;
      for (int i = 0; i < msg.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            valid_i = 1'b0;
            @(posedge clk);
         end
         acc = 1'b0;
         budget = 0;
         while (!acc) begin
            @(negedge clk);
            valid_i = 1'b1;
            byte_i  = msg[i];
            last_i  = (i == msg.size() - 1);
            acc     = in_ready_o;
            @(posedge clk);
            budget++;
            if (!acc && budget > 3000) begin
               total++; bad++;
               $display("FAIL byte_accept: byte %0d not taken in %0d cycles, need accept", i, budget);
               @(negedge clk);
               valid_i = 1'b0;
               return;
            end
         end
      end
      if (!keep) begin
         @(negedge clk);
         valid_i = 1'b0;
         last_i  = 1'b0;
      end
   endtask

   task automatic wait_done(input int target);
      int c = 0;
      while (n_done < target && c < 4000) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      total++;
      if (n_done < target) begin
         bad++;
         $display("FAIL done_timeout: done count %0d, need %0d", n_done, target);
      end
   endtask

   function automatic void fill(ref logic [7:0] q[$], input int n, input logic [7:0] v);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(v);
   endfunction

   // Behavioural core: after four loads, wait core_delay cycles then pulse ready with data.
   initial begin
      int ls = 0, wc = 0, bd = 0;
      core_ready_i = 1'b0;
      core_data_i  = '0;
      forever begin
         @(negedge clk);
         core_ready_i = 1'b0;
         if (!reset) begin
            ls = 0; wc = 0; bd = 0;
         end else if (load_o) begin
            ls++;
            if (ls > 4) over_loads++;
         end else if (ls >= 4) begin
            if (in_ready_o) ir_viol++;
            if (wc >= core_delay) begin
               bd++; ls = 0; wc = 0; n_ready++;
               if (msg_blk_q.size() > 0 && bd == msg_blk_q[0]) begin
                  core_data_i = fin_core_q.pop_front();
                  void'(msg_blk_q.pop_front());
                  bd = 0;
               end else begin
                  core_data_i = {$urandom, $urandom, $urandom, $urandom};
               end
               core_ready_i = 1'b1;
            end else begin
               wc++;
            end
         end
      end
   end

   // Output monitor and scoreboard.
   initial begin
      logic [127:0] e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            if (load_o) begin
               if (n_loads < 64) beats_log[n_loads] = blk_o;
               n_loads++;
               total++;
               if (exp_beats.size() == 0) begin
                  bad++;
                  $display("FAIL beat_unexpected: got %h, need no load", blk_o);
               end else begin
                  e = exp_beats.pop_front();
                  if (blk_o !== e) begin
                     bad++;
                     $display("FAIL beat %0d: got %h, need %h", n_loads - 1, blk_o, e);
                  end
               end
               total++;
               if (newtext_o !== 1'b0) begin
                  bad++;
                  $display("FAIL newtext_with_load: newtext %b, need 0", newtext_o);
               end
            end
            if (newtext_o) n_nt++;
            if (done_o) begin
               n_done++;
               total++;
               if (exp_dig.size() == 0) begin
                  bad++;
                  $display("FAIL done_unexpected: digest %h, need no done", digest_o);
               end else begin
                  e = exp_dig.pop_front();
                  if (digest_o !== e) begin
                     bad++;
                     $display("FAIL digest: got %h, need %h", digest_o, e);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0; valid_i = 1'b0; last_i = 1'b0; byte_i = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({in_ready_o, newtext_o, load_o, done_o} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ctrl: got %b, need 0000", {in_ready_o, newtext_o, load_o, done_o});
      end
      total++;
      if (blk_o !== '0 || digest_o !== '0) begin
         bad++;
         $display("FAIL reset_data: blk %h digest %h, need 0", blk_o, digest_o);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (in_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL idle_ready: got %b, need 1", in_ready_o);
      end
   endtask

   task automatic test_abc();
      logic [7:0] m[$];
      m = '{8'h61, 8'h62, 8'h63};
      clear_stats(); core_delay = 2;
      push_expect(m, ABC_CORE, ABC_DIG);
      send_bytes(m, 1'b0, 1'b0);
      wait_done(1);
      total++;
      if (beats_log[0][127:96] !== 32'h80636261) begin
         bad++; $display("FAIL abc_word0: got %h, need 80636261", beats_log[0][127:96]);
      end
      total++;
      if (beats_log[3][63:32] !== 32'h00000018) begin
         bad++; $display("FAIL abc_len: got %h, need 00000018", beats_log[3][63:32]);
      end
      total++;
      if (n_loads !== 4 || n_nt !== 1) begin
         bad++; $display("FAIL abc_counts: loads %0d newtext %0d, need 4 and 1", n_loads, n_nt);
      end
   endtask

   task automatic test_len55();
      logic [7:0] m[$];
      fill(m, 55, 8'h61);
      clear_stats(); core_delay = 5;
      push_expect(m, A_CORE, A_DIG);
      send_bytes(m, 1'b1, 1'b0);
      wait_done(1);
      total++;
      if (beats_log[3][63:32] !== 32'h000001B8) begin
         bad++; $display("FAIL len55_len: got %h, need 000001b8", beats_log[3][63:32]);
      end
      total++;
      if (n_ready !== 1 || n_loads !== 4) begin
         bad++; $display("FAIL len55_blocks: readies %0d loads %0d, need 1 and 4", n_ready, n_loads);
      end
   endtask

   task automatic test_len56();
      logic [7:0] m[$];
      fill(m, 56, 8'h61);
      clear_stats(); core_delay = 1;
      push_expect(m, ABC_CORE, ABC_DIG);
      send_bytes(m, 1'b1, 1'b0);
      wait_done(1);
      total++;
      if (n_loads !== 8 || n_done !== 1) begin
         bad++; $display("FAIL len56_counts: loads %0d done %0d, need 8 and 1", n_loads, n_done);
      end
      total++;
      if (beats_log[3][63:0] !== 64'h00000080_00000000) begin
         bad++; $display("FAIL len56_blk1_tail: got %h, need 0000008000000000", beats_log[3][63:0]);
      end
      total++;
      if (beats_log[7][63:32] !== 32'h000001C0) begin
         bad++; $display("FAIL len56_len: got %h, need 000001c0", beats_log[7][63:32]);
      end
   endtask

   task automatic test_len64();
      logic [7:0] m[$];
      fill(m, 64, 8'h61);
      clear_stats(); core_delay = 0;
      push_expect(m, A_CORE, A_DIG);
      send_bytes(m, 1'b0, 1'b0);
      wait_done(1);
      repeat (20) @(negedge clk);
      total++;
      if (n_loads !== 8 || n_done !== 1) begin
         bad++; $display("FAIL len64_counts: loads %0d done %0d, need 8 and 1", n_loads, n_done);
      end
      total++;
      if (beats_log[4][127:96] !== 32'h00000080 || beats_log[7][63:32] !== 32'h00000200) begin
         bad++; $display("FAIL len64_blk2: word0 %h len %h, need 00000080 00000200",
                         beats_log[4][127:96], beats_log[7][63:32]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1[$];
      logic [7:0] m2[$];
      for (int i = 0; i < 100; i++) m1.push_back(8'($urandom));
      for (int i = 0; i < 20; i++) m2.push_back(8'($urandom));
      clear_stats(); core_delay = 70;
      push_expect(m1, ABC_CORE, ABC_DIG);
      push_expect(m2, A_CORE, A_DIG);
      send_bytes(m1, 1'b0, 1'b1);
      send_bytes(m2, 1'b0, 1'b0);
      wait_done(2);
      total++;
      if (ir_viol !== 0 || over_loads !== 0) begin
         bad++; $display("FAIL b2b_wait: ready-in-wait %0d extra loads %0d, need 0 and 0", ir_viol, over_loads);
      end
      total++;
      if (n_nt !== 2 || n_loads !== 12 || exp_beats.size() !== 0) begin
         bad++; $display("FAIL b2b_counts: newtext %0d loads %0d left %0d, need 2 12 0",
                         n_nt, n_loads, exp_beats.size());
      end
   endtask

   task automatic test_reset_mid_pad();
      logic [7:0] m[$];
      m = '{8'h61, 8'h62, 8'h63};
      clear_stats(); core_delay = 3;
      send_bytes(m, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({in_ready_o, load_o, done_o, newtext_o} !== 4'b0000 || digest_o !== '0) begin
         bad++; $display("FAIL midpad_reset: ctrl %b digest %h, need 0000 and 0",
                         {in_ready_o, load_o, done_o, newtext_o}, digest_o);
      end
      reset = 1'b1;
      total++;
      if (n_loads !== 0) begin
         bad++; $display("FAIL midpad_aborted: loads %0d, need 0", n_loads);
      end
      m = '{8'h61};
      clear_stats();
      push_expect(m, A_CORE, A_DIG);
      send_bytes(m, 1'b0, 1'b0);
      wait_done(1);
      total++;
      if (n_nt !== 1 || n_loads !== 4 || beats_log[0][127:96] !== 32'h00008061) begin
         bad++; $display("FAIL midpad_restart: newtext %0d loads %0d word0 %h, need 1 4 00008061",
                         n_nt, n_loads, beats_log[0][127:96]);
      end
      total++;
      if (beats_log[3][63:32] !== 32'h00000008) begin
         bad++; $display("FAIL midpad_len: got %h, need 00000008", beats_log[3][63:32]);
      end
   endtask

   initial begin
      clear_stats();
      core_delay = 2;
      test_reset();
      test_abc();
      test_len55();
      test_len56();
      test_len64();
      test_back_to_back();
      test_reset_mid_pad();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
